// File: rtl/encoder_frame_sequencer.sv
// Per-frame launch controller: picks the latest captured cover slot, programs
// encoder addresses, pulses begin_encoding, waits for completion and rotates
// the stego output ring while keeping completed/dropped frame statistics.
module encoder_frame_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned NUM_SLOTS      = 3,
    parameter int unsigned SLOT_W         = 2,
    parameter int unsigned FRAME_BYTES    = 3686400,
    parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
    input  logic                  axi_clk,
    input  logic                  axi_resetn,
    input  logic                  enable,
    input  logic                  clear_stats,
    input  logic [ADDR_WIDTH-1:0] cimg_ring_baddr,
    input  logic [ADDR_WIDTH-1:0] simg_ring_baddr,
    input  logic [ADDR_WIDTH-1:0] msg_baddr_in,
    input  logic                  frame_ready,
    input  logic [SLOT_W-1:0]     frame_ready_slot,
    input  logic                  done_encoding,
    output logic [ADDR_WIDTH-1:0] cimg_baddr,
    output logic [ADDR_WIDTH-1:0] simg_baddr,
    output logic [ADDR_WIDTH-1:0] msg_baddr,
    output logic                  begin_encoding,
    output logic                  busy,
    output logic                  simg_frame_valid,
    output logic [SLOT_W-1:0]     simg_frame_slot,
    output logic [31:0]           frames_encoded,
    output logic [31:0]           frames_dropped,
    output logic                  timeout_err
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        START    = 3'd2,
        ENCODE   = 3'd3,
        COMPLETE = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [SLOT_W-1:0]     pending_slot_q, pending_slot_d;
    logic [SLOT_W-1:0]     out_slot_q, out_slot_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] cimg_q, cimg_d, simg_q, simg_d, msg_q, msg_d;
    logic                  begin_q, begin_d, busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [SLOT_W-1:0]     vslot_q, vslot_d;
    logic [CNT_W-1:0]      encoded_q, encoded_d, dropped_q, dropped_d;
    logic                  tout_q, tout_d;

    logic                  done_rise, launch, slot_ok, timeout_hit;
    logic [1:0]            drop_inc;

    // Next-state, pending bookkeeping, address programming and statistics
    always_comb begin
        done_rise       = done_encoding & ~done_q;
        launch          = (state_q == IDLE) & enable & pending_valid_q;
        slot_ok         = (32'(frame_ready_slot) < NUM_SLOTS);
        timeout_hit     = (state_q == ENCODE) & ~done_rise &
                          (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

        state_d         = state_q;
        pending_valid_d = pending_valid_q;
        pending_slot_d  = pending_slot_q;
        out_slot_d      = out_slot_q;
        wd_d            = wd_q;
        cimg_d          = cimg_q;
        simg_d          = simg_q;
        msg_d           = msg_q;
        vslot_d         = vslot_q;
        encoded_d       = encoded_q;
        dropped_d       = dropped_q;
        tout_d          = tout_q;
        drop_inc        = 2'd0;

        // The launch consumes the pending slot; a same-cycle arrival refills it
        if (launch) begin
            pending_valid_d = 1'b0;
        end
        if (frame_ready) begin
            if (slot_ok) begin
                if (pending_valid_q && !launch) begin
                    drop_inc = drop_inc + 2'd1;
                end
                pending_valid_d = 1'b1;
                pending_slot_d  = frame_ready_slot;
            end else begin
                drop_inc = drop_inc + 2'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = SETUP;
                    cimg_d  = cimg_ring_baddr +
                              ADDR_WIDTH'(pending_slot_q) * ADDR_WIDTH'(FRAME_BYTES);
                    simg_d  = simg_ring_baddr +
                              ADDR_WIDTH'(out_slot_q) * ADDR_WIDTH'(FRAME_BYTES);
                    msg_d   = msg_baddr_in;
                    wd_d    = '0;
                end
            end
            SETUP:  state_d = START;
            START:  state_d = ENCODE;
            ENCODE: begin
                if (done_rise) begin
                    state_d   = COMPLETE;
                    vslot_d   = out_slot_q;
                    encoded_d = encoded_q + CNT_W'(1);
                end else if (timeout_hit) begin
                    state_d  = IDLE;
                    tout_d   = 1'b1;
                    drop_inc = drop_inc + 2'd1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            COMPLETE: begin
                state_d    = IDLE;
                out_slot_d = (out_slot_q == SLOT_W'(NUM_SLOTS - 1)) ?
                             '0 : out_slot_q + SLOT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        dropped_d = dropped_q + CNT_W'(drop_inc);
        if (clear_stats) begin
            encoded_d = '0;
            dropped_d = '0;
            tout_d    = 1'b0;
        end

        begin_d = (state_d == START);
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == COMPLETE);
    end

    // State and output registers
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q         <= IDLE;
            pending_valid_q <= 1'b0;
            pending_slot_q  <= '0;
            out_slot_q      <= '0;
            wd_q            <= '0;
            done_q          <= 1'b0;
            cimg_q          <= '0;
            simg_q          <= '0;
            msg_q           <= '0;
            begin_q         <= 1'b0;
            busy_q          <= 1'b0;
            valid_q         <= 1'b0;
            vslot_q         <= '0;
            encoded_q       <= '0;
            dropped_q       <= '0;
            tout_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_valid_q <= pending_valid_d;
            pending_slot_q  <= pending_slot_d;
            out_slot_q      <= out_slot_d;
            wd_q            <= wd_d;
            done_q          <= done_encoding;
            cimg_q          <= cimg_d;
            simg_q          <= simg_d;
            msg_q           <= msg_d;
            begin_q         <= begin_d;
            busy_q          <= busy_d;
            valid_q         <= valid_d;
            vslot_q         <= vslot_d;
            encoded_q       <= encoded_d;
            dropped_q       <= dropped_d;
            tout_q          <= tout_d;
        end
    end

    assign cimg_baddr       = cimg_q;
    assign simg_baddr       = simg_q;
    assign msg_baddr        = msg_q;
    assign begin_encoding   = begin_q;
    assign busy             = busy_q;
    assign simg_frame_valid = valid_q;
    assign simg_frame_slot  = vslot_q;
    assign frames_encoded   = encoded_q;
    assign frames_dropped   = dropped_q;
    assign timeout_err      = tout_q;

endmodule

// File: tb/tb_encoder_frame_sequencer.sv
// Scoreboard bench for encoder_frame_sequencer: the driver pushes expected
// launches/completions, a negedge monitor pops and compares them.
module tb_encoder_frame_sequencer;

    localparam int unsigned AW = 32;
    localparam int unsigned NS = 3;
    localparam int unsigned SW = 2;
    localparam int unsigned FB = 3686400;
    localparam int unsigned TO = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          clear_stats = 1'b0;
    logic [AW-1:0] cbase = '0, sbase = '0, mbase = '0;
    logic          frame_ready = 1'b0;
    logic [SW-1:0] frame_ready_slot = '0;
    logic          done_encoding = 1'b0;
    logic [AW-1:0] cimg_baddr, simg_baddr, msg_baddr;
    logic          begin_encoding, busy, simg_frame_valid, timeout_err;
    logic [SW-1:0] simg_frame_slot;
    logic [31:0]   frames_encoded, frames_dropped;

    encoder_frame_sequencer #(
        .ADDR_WIDTH(AW), .NUM_SLOTS(NS), .SLOT_W(SW),
        .FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .axi_clk(clk), .axi_resetn(rst_n), .enable(enable),
        .clear_stats(clear_stats), .cimg_ring_baddr(cbase),
        .simg_ring_baddr(sbase), .msg_baddr_in(mbase),
        .frame_ready(frame_ready), .frame_ready_slot(frame_ready_slot),
        .done_encoding(done_encoding), .cimg_baddr(cimg_baddr),
        .simg_baddr(simg_baddr), .msg_baddr(msg_baddr),
        .begin_encoding(begin_encoding), .busy(busy),
        .simg_frame_valid(simg_frame_valid), .simg_frame_slot(simg_frame_slot),
        .frames_encoded(frames_encoded), .frames_dropped(frames_dropped),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] c;
        logic [AW-1:0] s;
        logic [AW-1:0] m;
    } launch_t;

    launch_t     launch_q[$];
    int          slot_q[$];
    int          pre_slots[$];
    int          enc_slots[$];
    int          errors = 0;
    int          checks = 0;

    // Transaction-level model of the sequencer
    bit          m_pend_v = 0;
    int          m_pend = 0;
    int          m_out = 0;
    int unsigned m_enc = 0, m_drop = 0;
    bit          m_to = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred that the model did not predict", name);
    endtask

    function automatic logic [AW-1:0] slot_addr(input logic [AW-1:0] base, input int slot);
        longint unsigned a;
        a = longint'(base) + longint'(slot) * longint'(FB);
        return AW'(a);
    endfunction

    function automatic void model_ready(input int s);
        if (s >= int'(NS)) begin
            m_drop++;
        end else begin
            if (m_pend_v) m_drop++;
            m_pend_v = 1;
            m_pend   = s;
        end
    endfunction

    // Monitor: compare every launch and completion against the scoreboard
    logic [AW-1:0] prev_c, prev_s, prev_m;
    launch_t       lx;
    int            ex_slot;
    always @(negedge clk) begin
        if (rst_n) begin
            if (begin_encoding) begin
                if (launch_q.size() == 0) begin
                    fail_evt("unexpected_begin");
                end else begin
                    lx = launch_q.pop_front();
                    check("launch_cimg", 64'(cimg_baddr), 64'(lx.c));
                    check("launch_simg", 64'(simg_baddr), 64'(lx.s));
                    check("launch_msg", 64'(msg_baddr), 64'(lx.m));
                    check("addr_before_begin", {prev_c, prev_s}, {lx.c, lx.s});
                    check("msg_before_begin", 64'(prev_m), 64'(lx.m));
                end
            end
            if (simg_frame_valid) begin
                if (slot_q.size() == 0) begin
                    fail_evt("unexpected_valid");
                end else begin
                    ex_slot = slot_q.pop_front();
                    check("valid_slot", 64'(simg_frame_slot), 64'(ex_slot));
                end
            end
        end
        prev_c = cimg_baddr;
        prev_s = simg_baddr;
        prev_m = msg_baddr;
    end

    task automatic wait_begin(output int n);
        bit found;
        found = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            frame_ready = 1'b0;
            n++;
            if (begin_encoding) begin
                found = 1;
                break;
            end
        end
        if (!found) fail_evt("begin_timeout");
    endtask

    task automatic wait_idle(input int limit);
        bit found;
        found = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) begin
                found = 1;
                break;
            end
        end
        if (!found) fail_evt("idle_timeout");
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_encoded"}, 64'(frames_encoded), 64'(m_enc));
        check({tag, "_dropped"}, 64'(frames_dropped), 64'(m_drop));
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'(m_to));
    endtask

    task automatic send_ready(input int s);
        model_ready(s);
        frame_ready      = 1'b1;
        frame_ready_slot = SW'(s);
        @(negedge clk);
    endtask

    // One frame: pulses while idle/disabled, launch, pulses while encoding,
    // then completion (mode 1) or watchdog expiry (mode 0)
    task automatic episode(input int mode, input int dly);
        int n;
        foreach (pre_slots[i]) send_ready(pre_slots[i]);
        if (!m_pend_v) send_ready(int'($urandom_range(0, NS - 1)));
        frame_ready = 1'b0;
        if (mode == 0) done_encoding = 1'b0;
        launch_q.push_back('{slot_addr(cbase, m_pend), slot_addr(sbase, m_out), mbase});
        m_pend_v = 0;
        enable = 1'b1;
        wait_begin(n);
        check("launch_latency", 64'(n), 64'd2);
        enable = 1'b0;
        foreach (enc_slots[i]) send_ready(enc_slots[i]);
        frame_ready = 1'b0;
        if (mode == 0) begin
            wait_idle(TO + 50);
            m_drop++;
            m_to = 1;
        end else begin
            repeat (dly) @(negedge clk);
            if (done_encoding) begin
                check("held_done_no_complete", 64'(busy), 64'd1);
                done_encoding = 1'b0;
                @(negedge clk);
            end
            slot_q.push_back(m_out);
            done_encoding = 1'b1;
            m_out = (m_out == int'(NS) - 1) ? 0 : m_out + 1;
            m_enc++;
            wait_idle(10);
            if ($urandom_range(0, 1) == 0) done_encoding = 1'b0;
        end
        check_stats(mode == 0 ? "timeout" : "frame");
    endtask

    initial begin
        int n;
        #1;
        check("rst_addrs", {cimg_baddr, simg_baddr}, 64'd0);
        check("rst_msg", 64'(msg_baddr), 64'd0);
        check("rst_flags", {begin_encoding, busy, simg_frame_valid, simg_frame_slot, timeout_err}, 64'd0);
        check("rst_counters", {frames_encoded, frames_dropped}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First frame: fixed bases, slot 2, check 3-cycle launch latency
        cbase = 32'h1000_0000;
        sbase = 32'h2000_0000;
        mbase = 32'h3000_0000;
        enable = 1'b1;
        @(negedge clk);
        frame_ready = 1'b1;
        frame_ready_slot = 2'd2;
        launch_q.push_back('{32'h1070_8000, 32'h2000_0000, 32'h3000_0000});
        wait_begin(n);
        check("first_latency", 64'(n), 64'd3);
        enable = 1'b0;
        repeat (100) @(negedge clk);
        slot_q.push_back(0);
        done_encoding = 1'b1;
        m_out = 1;
        m_enc = 1;
        wait_idle(10);
        done_encoding = 1'b0;
        check_stats("frame1");

        // Three pulses during ENCODE: two drops, latest slot launches next
        pre_slots = '{1};
        enc_slots = '{0, 1, 2};
        episode(1, 30);
        check("three_pulse_drops", 64'(frames_dropped), 64'd2);
        pre_slots.delete();
        enc_slots.delete();
        episode(1, 20);
        check("cover_slot2_reused", 64'(cimg_baddr), 64'(slot_addr(cbase, 2)));

        // Watchdog expiry, then the same stego slot must be reused
        episode(0, 0);
        episode(1, 10);

        // Randomized frames
        for (int e = 0; e < 25; e++) begin
            cbase = $urandom;
            sbase = $urandom;
            mbase = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                clear_stats = 1'b1;
                @(negedge clk);
                clear_stats = 1'b0;
                m_enc = 0;
                m_drop = 0;
                m_to = 0;
                @(negedge clk);
                check_stats("clear");
            end
            pre_slots.delete();
            enc_slots.delete();
            repeat ($urandom_range(0, 3)) pre_slots.push_back(int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) enc_slots.push_back(int'($urandom_range(0, 3)));
            episode(($urandom_range(0, 6) == 0) ? 0 : 1, int'($urandom_range(5, 90)));
        end

        // Reset in the middle of ENCODE
        pre_slots.delete();
        enc_slots.delete();
        done_encoding = 1'b0;
        send_ready(1);
        frame_ready = 1'b0;
        launch_q.push_back('{slot_addr(cbase, m_pend), slot_addr(sbase, m_out), mbase});
        m_pend_v = 0;
        enable = 1'b1;
        wait_begin(n);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_addrs", {cimg_baddr, simg_baddr}, 64'd0);
        check("midrst_flags", {begin_encoding, busy, simg_frame_valid, simg_frame_slot, timeout_err}, 64'd0);
        check("midrst_counters", {frames_encoded, frames_dropped}, 64'd0);
        m_out = 0;
        m_enc = 0;
        m_drop = 0;
        m_to = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);
        enable = 1'b0;
        pre_slots = '{1};
        episode(1, 15);

        check("launch_q_empty", 64'(launch_q.size()), 64'd0);
        check("slot_q_empty", 64'(slot_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder_frame_sequencer.md
Name: encoder_frame_sequencer

Overview:
- Per-frame launch controller for real-time encoding. Sits directly upstream of the encoder top level, in the axi_clk domain, between the video-capture DMA and the encoder's register-driven start interface.
- Tracks cover-frame slots filled by capture. For each frame it programs the cover, stego and message base addresses, then pulses begin_encoding and waits for done_encoding.
- Rotates the stego output slots, reports completed frames to the display side, and counts dropped and timed-out frames.

Parameters:
- ADDR_WIDTH, 32, width of all byte addresses.
- NUM_SLOTS, 3, frame buffers per ring (cover ring and stego ring); must be at least 2.
- SLOT_W, 2, width of slot indices; clog2(NUM_SLOTS).
- FRAME_BYTES, 3686400, byte stride between slots (1280*720*32/8).
- TIMEOUT_CYCLES, 16777216, watchdog limit in ENCODE, in axi_clk cycles.

Ports:
- axi_clk  in  1  clock.
- axi_resetn  in  1  reset; asynchronous, active-low.
- enable  in  1  level; permits new launches.
- clear_stats  in  1  pulse; zeroes both counters and timeout_err.
- cimg_ring_baddr  in  ADDR_WIDTH  base of cover slot 0.
- simg_ring_baddr  in  ADDR_WIDTH  base of stego slot 0.
- msg_baddr_in  in  ADDR_WIDTH  message base, reused every frame.
- frame_ready  in  1  pulse; capture finished writing cover slot frame_ready_slot.
- frame_ready_slot  in  SLOT_W  slot index, valid with frame_ready.
- done_encoding  in  1  encoder completion, rising-edge qualified.
- cimg_baddr  out  ADDR_WIDTH  cover address to encoder.
- simg_baddr  out  ADDR_WIDTH  stego address to encoder.
- msg_baddr  out  ADDR_WIDTH  message address to encoder.
- begin_encoding  out  1  single-cycle start pulse.
- busy  out  1  high in any state other than IDLE.
- simg_frame_valid  out  1  single-cycle pulse; a stego frame is complete.
- simg_frame_slot  out  SLOT_W  stego slot just completed, valid with simg_frame_valid.
- frames_encoded  out  32  completed-frame counter.
- frames_dropped  out  32  overwritten plus timed-out frame counter.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async assert, sync release) clears:
  - all outputs to 0;
  - state to IDLE;
  - pending_valid, out_slot, watchdog and done_q.
- Pending register (latest-wins):
  - frame_ready sets pending_valid and pending_slot.
  - If pending_valid is already 1 and is not being consumed this cycle: overwrite pending_slot and increment frames_dropped.
  - If frame_ready coincides with consumption in SETUP: the new slot becomes pending and no drop is counted.
  - Out-of-range slot (>= NUM_SLOTS): ignored and counted as a drop.
- done_q <= done_encoding every cycle. done_rise = done_encoding & ~done_q.
- IDLE:
  - If enable & pending_valid, go to SETUP; otherwise stay.
- SETUP (1 cycle), registering:
  - cimg_baddr <= cimg_ring_baddr + pending_slot*FRAME_BYTES;
  - simg_baddr <= simg_ring_baddr + out_slot*FRAME_BYTES;
  - msg_baddr <= msg_baddr_in;
  - clear pending_valid and the watchdog; go to START.
  - Address arithmetic is modulo 2^ADDR_WIDTH.
  - Address outputs hold until the next SETUP.
- START (1 cycle):
  - begin_encoding = 1; go to ENCODE.
  - Addresses are stable at least one cycle before begin_encoding.
- ENCODE:
  - Watchdog increments each cycle.
  - done_rise: go to COMPLETE.
  - Watchdog reaching TIMEOUT_CYCLES-1 without done_rise: set timeout_err, increment frames_dropped, go to IDLE. out_slot is not advanced and no valid pulse is issued.
  - A done level already high on entry does not complete the frame; a rising edge is required.
- COMPLETE (1 cycle):
  - simg_frame_valid = 1 with simg_frame_slot = out_slot.
  - frames_encoded++.
  - out_slot <= (out_slot == NUM_SLOTS-1) ? 0 : out_slot+1.
  - Go to IDLE.
- enable deasserted mid-frame: the current frame runs to COMPLETE or timeout; no further launch. Pending is retained.
- Counters wrap at 2^32.
- clear_stats has priority over a same-cycle increment; the result is 0.
- Latency:
  - frame_ready to begin_encoding = 3 cycles when IDLE and enabled (IDLE, SETUP, START).
  - done_rise to simg_frame_valid = 1 cycle.

Test Plan:
- Reset, then enable=1, bases 0x1000_0000 / 0x2000_0000 / 0x3000_0000, frame_ready slot 2 -> begin_encoding 3 cycles later; cimg_baddr=0x1070_8000, simg_baddr=0x2000_0000, msg_baddr=0x3000_0000.
- done_encoding rises 100 cycles after begin -> one-cycle simg_frame_valid with slot 0; frames_encoded=1; the next frame uses simg slot 1, and after slot 2 it wraps to 0.
- Three frame_ready pulses (slots 0, 1, 2) while ENCODE is busy -> frames_dropped=2; the next launch uses cover slot 2.
- TIMEOUT_CYCLES=64 and no done -> timeout_err=1, frames_dropped=1, no valid pulse; the following frame reuses the same simg slot.
- done_encoding held high from the previous frame into ENCODE -> no completion until it drops and rises again.
- axi_resetn asserted mid-ENCODE -> all outputs 0 immediately; after release, begin_encoding is not issued until a new frame_ready.
